// File: rtl/note_plot_scheduler.sv
// note_plot_scheduler
//   Draws the recorded note sequence as a piano-roll on a 160x120 VGA adapter.
//   It accepts single-shot draw-slot and clear-screen requests and drives one
//   pixel per clock to the adapter.
//   A draw erases the slot's column, then paints one block for the note.
//   A rest erases the column only. A clear fills the whole screen.
// Ports
//   clk, reset (sync, active-low)
//   draw_req, draw_slot[3:0], draw_note[3:0], draw_octave[1:0]  draw request
//   clear_req                                                  clear request
//   busy, done                                                 handshake status
//   x[7:0], y[6:0], colour[2:0], writeEn                       adapter plot bus
module note_plot_scheduler #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int BLOCK_W = 8,
  parameter int BLOCK_H = 2,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       draw_req,
  input  logic [3:0] draw_slot,
  input  logic [3:0] draw_note,
  input  logic [1:0] draw_octave,
  input  logic       clear_req,
  output logic       busy,
  output logic       done,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       writeEn
);

  typedef enum logic [2:0] {IDLE, ERASE, BLOCK, CLEAR, FINISH} state_t;

  localparam logic [7:0] X_MAX = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_MAX = 7'(SCREEN_H - 1);

  state_t     state_reg, state_next;
  logic [7:0] px_reg, px_next;
  logic [6:0] py_reg, py_next;
  logic [3:0] slot_reg, note_reg;
  logic [1:0] octave_reg;
  logic       latch;
  logic       emit;
  logic       fin;
  logic [2:0] emit_colour;

  logic [7:0] x_reg;
  logic [6:0] y_reg;
  logic [2:0] colour_reg;
  logic       write_en_reg, busy_reg, done_reg;

  logic [7:0] x0_in, x0, x_last;
  logic [5:0] row;
  logic [6:0] y0, y_blk_last;

  assign x0_in      = 8'(int'(draw_slot) * BLOCK_W);
  assign x0         = 8'(int'(slot_reg) * BLOCK_W);
  assign x_last     = 8'(int'(x0) + BLOCK_W - 1);
  assign row        = 6'(int'(octave_reg) * 12 + int'(note_reg));
  assign y0         = 7'(SCREEN_H - BLOCK_H * (int'(row) + 1));
  assign y_blk_last = 7'(int'(y0) + BLOCK_H - 1);

  // The pixel walker (state_reg/px_reg/py_reg) runs one cycle ahead of the
  // registered adapter outputs. That gap gives the one-cycle acceptance
  // latency, and it keeps FINISH aligned with the done pulse.
  always_comb begin
    state_next  = state_reg;
    px_next     = px_reg;
    py_next     = py_reg;
    latch       = 1'b0;
    emit        = 1'b0;
    fin         = 1'b0;
    emit_colour = BG_COLOUR;
    case (state_reg)
      IDLE: begin
        // done_reg high means the done cycle is still showing. Requests
        // seen in that cycle are dropped along with the operation.
        if (!done_reg) begin
          if (clear_req) begin
            state_next = CLEAR;
            px_next    = 8'd0;
            py_next    = 7'd0;
          end else if (draw_req) begin
            state_next = ERASE;
            px_next    = x0_in;
            py_next    = 7'd0;
            latch      = 1'b1;
          end
        end
      end
      ERASE: begin
        emit = 1'b1;
        if (px_reg == x_last) begin
          px_next = x0;
          if (py_reg == Y_MAX) begin
            if (note_reg < 4'd12) begin
              state_next = BLOCK;
              py_next    = y0;
            end else begin
              state_next = FINISH;
            end
          end else begin
            py_next = py_reg + 7'd1;
          end
        end else begin
          px_next = px_reg + 8'd1;
        end
      end
      BLOCK: begin
        emit        = 1'b1;
        emit_colour = {1'b0, octave_reg} + 3'd1;
        if (px_reg == x_last) begin
          px_next = x0;
          if (py_reg == y_blk_last) state_next = FINISH;
          else py_next = py_reg + 7'd1;
        end else begin
          px_next = px_reg + 8'd1;
        end
      end
      CLEAR: begin
        emit = 1'b1;
        if (px_reg == X_MAX) begin
          px_next = 8'd0;
          if (py_reg == Y_MAX) state_next = FINISH;
          else py_next = py_reg + 7'd1;
        end else begin
          px_next = px_reg + 8'd1;
        end
      end
      FINISH: begin
        fin        = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      px_reg       <= 8'd0;
      py_reg       <= 7'd0;
      slot_reg     <= 4'd0;
      note_reg     <= 4'd0;
      octave_reg   <= 2'd0;
      x_reg        <= 8'd0;
      y_reg        <= 7'd0;
      colour_reg   <= 3'd0;
      write_en_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      px_reg    <= px_next;
      py_reg    <= py_next;
      if (latch) begin
        slot_reg   <= draw_slot;
        note_reg   <= draw_note;
        octave_reg <= draw_octave;
      end
      // x/y/colour keep the last plotted pixel while writeEn is low.
      if (emit) begin
        x_reg      <= px_reg;
        y_reg      <= py_reg;
        colour_reg <= emit_colour;
      end
      write_en_reg <= emit;
      busy_reg     <= emit;
      done_reg     <= fin;
    end
  end

  assign x       = x_reg;
  assign y       = y_reg;
  assign colour  = colour_reg;
  assign writeEn = write_en_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_note_plot_scheduler.sv
// tb_note_plot_scheduler
//   Directed bench for note_plot_scheduler. It checks reset, clear, draw,
//   rest, arbitration and abort, with hand-derived pixel sequences.
module tb_note_plot_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       draw_req;
  logic [3:0] draw_slot;
  logic [3:0] draw_note;
  logic [1:0] draw_octave;
  logic       clear_req;
  logic       busy, done, writeEn;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;

  int tests = 0;
  int fails = 0;

  int qx[$];
  int qy[$];
  int qc[$];

  note_plot_scheduler dut (
    .clk(clk), .reset(reset),
    .draw_req(draw_req), .draw_slot(draw_slot), .draw_note(draw_note),
    .draw_octave(draw_octave), .clear_req(clear_req),
    .busy(busy), .done(done), .x(x), .y(y), .colour(colour), .writeEn(writeEn)
  );

  always #5 clk = ~clk;

  // Expected i-th pixel of a draw: erase the column top to bottom, then the
  // block, if the note is not a rest.
  function automatic void exp_draw(input int slot, input int note, input int oct,
                                   input int i, output int ex, output int ey,
                                   output int ec);
    int x0, y0, j;
    x0 = slot * 8;
    if (i < 960) begin
      ex = x0 + i % 8;
      ey = i / 8;
      ec = 0;
    end else begin
      j  = i - 960;
      y0 = 120 - 2 * (oct * 12 + note + 1);
      ex = x0 + j % 8;
      ey = y0 + j / 8;
      ec = oct + 1;
    end
  endfunction

  // Collects plotted pixels until done or until the budget runs out. The
  // first sample is the cycle after the acceptance cycle. If inject_at is
  // 0 or more, a one-cycle draw_req for slot 9 is pulsed once that many
  // writes have been seen.
  task automatic collect(input int budget, input int inject_at,
                         output int nw, output int first_cyc, output int gaps,
                         output int busy_err, output bit got_done,
                         output bit done_ok);
    int last_cyc;
    bit injected;
    qx.delete(); qy.delete(); qc.delete();
    nw = 0; first_cyc = -1; gaps = 0; busy_err = 0;
    got_done = 1'b0; done_ok = 1'b0; last_cyc = -1; injected = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      draw_req = 1'b0;
      if (writeEn) begin
        qx.push_back(int'(x)); qy.push_back(int'(y)); qc.push_back(int'(colour));
        if (first_cyc < 0) first_cyc = cyc;
        if (last_cyc >= 0 && cyc != last_cyc + 1) gaps++;
        last_cyc = cyc;
        if (!busy || done) busy_err++;
        nw++;
        if (inject_at >= 0 && !injected && nw >= inject_at) begin
          injected = 1'b1;
          draw_req = 1'b1; draw_slot = 4'd9; draw_note = 4'd3; draw_octave = 2'd2;
        end
      end else if (done) begin
        got_done = 1'b1;
        done_ok = (busy == 1'b0) && (cyc == last_cyc + 1);
        break;
      end else if (busy) begin
        busy_err++;
      end
    end
    draw_req = 1'b0;
  endtask

  // Starts a draw from a negedge. It returns at the negedge of the
  // acceptance cycle.
  task automatic start_draw(input int slot, input int note, input int oct);
    @(negedge clk);
    draw_req = 1'b1; draw_slot = 4'(slot); draw_note = 4'(note); draw_octave = 2'(oct);
    @(negedge clk);
    draw_req = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; draw_req = 1'b1; clear_req = 1'b0;
    draw_slot = 4'd3; draw_note = 4'd1; draw_octave = 2'd0;
    repeat (2) begin
      @(negedge clk);
      tests++;
      if ({writeEn, busy, done} !== 3'b000 || x !== 8'd0 || y !== 7'd0) begin
        fails++;
        $display("FAIL reset_outputs: we=%b busy=%b done=%b x=%0d y=%0d, required all 0",
                 writeEn, busy, done, x, y);
      end
    end
    draw_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (writeEn !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_idle: we=%b busy=%b, required 0 0", writeEn, busy);
    end
  endtask

  task automatic test_clear;
    int nw, fc, gaps, berr, bad;
    bit gd, dok;
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    tests++;
    if (writeEn !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL clear_accept_cycle: we=%b busy=%b, required 0 0", writeEn, busy);
    end
    collect(20000, -1, nw, fc, gaps, berr, gd, dok);
    tests++;
    if (nw !== 19200) begin
      fails++; $display("FAIL clear_count: got %0d writes, required 19200", nw);
    end
    tests++;
    if (fc !== 0) begin
      fails++; $display("FAIL clear_latency: first write at cycle %0d, required 0", fc);
    end
    bad = 0;
    foreach (qx[i]) if (qx[i] != i % 160 || qy[i] != i / 160 || qc[i] != 0) bad++;
    tests++;
    if (bad !== 0 || gaps !== 0 || berr !== 0) begin
      fails++;
      $display("FAIL clear_sequence: bad=%0d gaps=%0d busy_err=%0d, required 0 0 0",
               bad, gaps, berr);
    end
    tests++;
    if (nw > 0 && (qx[0] != 0 || qy[0] != 0 || qx[nw-1] != 159 || qy[nw-1] != 119)) begin
      fails++;
      $display("FAIL clear_ends: first (%0d,%0d) last (%0d,%0d), required (0,0) (159,119)",
               qx[0], qy[0], qx[nw-1], qy[nw-1]);
    end
    tests++;
    if (!gd || !dok) begin
      fails++; $display("FAIL clear_done: got_done=%b done_ok=%b, required 1 1", gd, dok);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || writeEn !== 1'b0 || x !== 8'd159 || y !== 7'd119) begin
      fails++;
      $display("FAIL clear_after: done=%b we=%b x=%0d y=%0d, required 0 0 159 119",
               done, writeEn, x, y);
    end
  endtask

  task automatic test_draw;
    int nw, fc, gaps, berr, bad, outside, ex, ey, ec;
    bit gd, dok;
    start_draw(2, 5, 1);
    collect(2000, -1, nw, fc, gaps, berr, gd, dok);
    tests++;
    if (nw !== 976 || fc !== 0) begin
      fails++; $display("FAIL draw_count: got %0d writes first at %0d, required 976 at 0", nw, fc);
    end
    bad = 0; outside = 0;
    foreach (qx[i]) begin
      exp_draw(2, 5, 1, i, ex, ey, ec);
      if (qx[i] != ex || qy[i] != ey || qc[i] != ec) bad++;
      if (qx[i] < 16 || qx[i] > 23) outside++;
    end
    tests++;
    if (bad !== 0 || outside !== 0 || gaps !== 0 || berr !== 0) begin
      fails++;
      $display("FAIL draw_sequence: bad=%0d outside=%0d gaps=%0d busy_err=%0d, required 0",
               bad, outside, gaps, berr);
    end
    tests++;
    if (nw == 976 && (qy[960] != 84 || qy[975] != 85 || qc[975] != 2)) begin
      fails++;
      $display("FAIL draw_block: y %0d..%0d colour %0d, required 84..85 colour 2",
               qy[960], qy[975], qc[975]);
    end
    tests++;
    if (!gd || !dok) begin
      fails++; $display("FAIL draw_done: got_done=%b done_ok=%b, required 1 1", gd, dok);
    end
  endtask

  task automatic test_rest;
    int nw, fc, gaps, berr, bad, ex, ey, ec;
    bit gd, dok;
    start_draw(15, 12, 3);
    collect(2000, -1, nw, fc, gaps, berr, gd, dok);
    bad = 0;
    foreach (qx[i]) begin
      exp_draw(15, 12, 3, i, ex, ey, ec);
      if (qx[i] != ex || qy[i] != ey || qc[i] != ec) bad++;
    end
    tests++;
    if (nw !== 960 || bad !== 0 || gaps !== 0) begin
      fails++;
      $display("FAIL rest_erase: writes=%0d bad=%0d gaps=%0d, required 960 0 0", nw, bad, gaps);
    end
    tests++;
    if (!gd || !dok) begin
      fails++; $display("FAIL rest_done: got_done=%b done_ok=%b, required 1 1", gd, dok);
    end
  endtask

  task automatic test_arbitration;
    int nw, fc, gaps, berr, bad, extra, ex, ey, ec;
    bit gd, dok;
    // Simultaneous requests: the clear wins and the draw is dropped.
    @(negedge clk);
    clear_req = 1'b1; draw_req = 1'b1;
    draw_slot = 4'd4; draw_note = 4'd0; draw_octave = 2'd3;
    @(negedge clk);
    clear_req = 1'b0; draw_req = 1'b0;
    collect(20000, -1, nw, fc, gaps, berr, gd, dok);
    bad = 0;
    foreach (qx[i]) if (qx[i] != i % 160 || qy[i] != i / 160 || qc[i] != 0) bad++;
    tests++;
    if (nw !== 19200 || bad !== 0 || !gd) begin
      fails++;
      $display("FAIL arb_clear_wins: writes=%0d bad=%0d done=%b, required 19200 0 1", nw, bad, gd);
    end
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (writeEn || busy) extra++;
    end
    tests++;
    if (extra !== 0) begin
      fails++; $display("FAIL arb_draw_dropped: %0d active cycles, required 0", extra);
    end
    // A draw pulsed mid-operation and in the done cycle is ignored.
    start_draw(0, 0, 0);
    collect(2000, 100, nw, fc, gaps, berr, gd, dok);
    bad = 0;
    foreach (qx[i]) begin
      exp_draw(0, 0, 0, i, ex, ey, ec);
      if (qx[i] != ex || qy[i] != ey || qc[i] != ec) bad++;
    end
    tests++;
    if (nw !== 976 || bad !== 0 || !gd) begin
      fails++;
      $display("FAIL arb_busy_ignore: writes=%0d bad=%0d done=%b, required 976 0 1", nw, bad, gd);
    end
    draw_req = 1'b1; draw_slot = 4'd5; draw_note = 4'd1; draw_octave = 2'd1;
    @(negedge clk);
    draw_req = 1'b0;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (writeEn || busy) extra++;
    end
    tests++;
    if (extra !== 0) begin
      fails++; $display("FAIL arb_finish_ignore: %0d active cycles, required 0", extra);
    end
  endtask

  task automatic test_abort;
    int nw, fc, gaps, berr, seen, active;
    bit gd, dok;
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    seen = 0;
    for (int c = 0; c < 1000 && seen < 500; c++) begin
      @(negedge clk);
      if (writeEn) seen++;
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (seen !== 500 || writeEn !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_stop: seen=%0d we=%b done=%b busy=%b, required 500 0 0 0",
               seen, writeEn, done, busy);
    end
    reset = 1'b1;
    active = 0;
    repeat (10) begin
      @(negedge clk);
      if (writeEn || done || busy) active++;
    end
    tests++;
    if (active !== 0) begin
      fails++; $display("FAIL abort_no_done: %0d active cycles, required 0", active);
    end
    start_draw(15, 13, 0);
    collect(2000, -1, nw, fc, gaps, berr, gd, dok);
    tests++;
    if (nw !== 960 || fc !== 0 || !gd || !dok) begin
      fails++;
      $display("FAIL abort_new_draw: writes=%0d first=%0d done=%b ok=%b, required 960 0 1 1",
               nw, fc, gd, dok);
    end
  endtask

  initial begin
    reset = 1'b0; draw_req = 1'b0; clear_req = 1'b0;
    draw_slot = 4'd0; draw_note = 4'd0; draw_octave = 2'd0;
    test_reset();
    test_clear();
    test_draw();
    test_rest();
    test_arbitration();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
